// File: rtl/imem_refill_ctrl_if.sv
// Request, refill and instruction-memory port bundle for imem_refill_ctrl.
// master = requesters plus memory model, slave = the controller.
interface imem_refill_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 2
);
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              refill_valid;
  logic [IDX_W-1:0]  refill_idx;
  logic [31:0]       refill_data;
  logic              refill_done;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ack;
  logic              busy;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport master (
    output miss_req, miss_addr, ld_req, ld_addr, ld_data, mem_dout,
    input  refill_valid, refill_idx, refill_data, refill_done, ld_ack, busy,
           mem_ren, mem_wen, mem_addr, mem_din
  );

  modport slave (
    input  miss_req, miss_addr, ld_req, ld_addr, ld_data, mem_dout,
    output refill_valid, refill_idx, refill_data, refill_done, ld_ack, busy,
           mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/imem_refill_ctrl.sv
// Instruction-memory sequencer: multi-beat I-cache line refills and single-beat loader writes.
// Refill beats start MEM_LATENCY cycles after acceptance; requests arriving while busy wait at their level.
module imem_refill_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  imem_refill_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, LAT, BURST} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  idx;
  logic [LAT_W-1:0]  cnt;
  logic              ren_q, wen_q, valid_q, done_q, ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic [ADDR_W-1:0] miss_base;
  logic [IDX_W-1:0]  nxt_idx;

  assign miss_base = bus.miss_addr & ~LINE_MASK;
  assign nxt_idx   = idx + IDX_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      base    <= '0;
      idx     <= '0;
      cnt     <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      wen_q  <= 1'b0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_req) begin
            state  <= WRITE;
            wen_q  <= 1'b1;
            ack_q  <= 1'b1;
            addr_q <= bus.ld_addr;
            din_q  <= bus.ld_data;
          end else if (bus.miss_req) begin
            base   <= miss_base;
            idx    <= '0;
            addr_q <= miss_base;
            ren_q  <= 1'b1;
            if (MEM_LATENCY > 0) begin
              state <= LAT;
              cnt   <= LAT_W'(MEM_LATENCY - 1);
            end else begin
              state   <= BURST;
              valid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          state  <= IDLE;
          addr_q <= '0;
          din_q  <= '0;
        end
        LAT: begin
          if (cnt == '0) begin
            state   <= BURST;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        BURST: begin
          if (idx == LAST_IDX) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ren_q   <= 1'b0;
            addr_q  <= '0;
            base    <= '0;
            idx     <= '0;
          end else begin
            // base is line-aligned, so OR-ing the index never carries out of the line
            idx    <= nxt_idx;
            addr_q <= base | {{(ADDR_W-IDX_W){1'b0}}, nxt_idx};
            done_q <= (nxt_idx == LAST_IDX);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing on a WRITE or final-beat cycle must suppress the write and the pulses
  assign bus.mem_wen      = wen_q & ~reset;
  assign bus.ld_ack       = ack_q & ~reset;
  assign bus.refill_done  = done_q & ~reset;
  assign bus.mem_ren      = ren_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_din      = din_q;
  assign bus.refill_valid = valid_q;
  assign bus.refill_idx   = idx;
  assign bus.refill_data  = valid_q ? bus.mem_dout : 32'd0;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_imem_refill_ctrl.sv
// Directed bench for imem_refill_ctrl: default instance (a) and a zero-latency 8-word instance (b).
module tb_imem_refill_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  imem_refill_ctrl_if #(.ADDR_W(10), .IDX_W(2)) ifa ();
  imem_refill_ctrl_if #(.ADDR_W(10), .IDX_W(3)) ifb ();

  imem_refill_ctrl #(.ADDR_W(10), .BLOCK_WORDS(4), .MEM_LATENCY(2))
    u_a (.clock(clock), .reset(reset), .bus(ifa.slave));
  imem_refill_ctrl #(.ADDR_W(10), .BLOCK_WORDS(8), .MEM_LATENCY(0))
    u_b (.clock(clock), .reset(reset), .bus(ifb.slave));

  // Memory models: unwritten words read as a fixed address-derived pattern
  logic [31:0] mem_a [1024];
  bit          wr_a  [1024];
  logic [31:0] mem_b [1024];
  bit          wr_b  [1024];
  always @(posedge clock) begin
    if (ifa.mem_wen) begin
      mem_a[ifa.mem_addr] <= ifa.mem_din;
      wr_a[ifa.mem_addr]  <= 1'b1;
    end
    if (ifb.mem_wen) begin
      mem_b[ifb.mem_addr] <= ifb.mem_din;
      wr_b[ifb.mem_addr]  <= 1'b1;
    end
  end
  assign ifa.mem_dout = wr_a[ifa.mem_addr] ? mem_a[ifa.mem_addr] : {22'h280000, ifa.mem_addr};
  assign ifb.mem_dout = wr_b[ifb.mem_addr] ? mem_b[ifb.mem_addr] : {22'h2C0000, ifb.mem_addr};

  // Bench-side expectation of memory contents
  logic [31:0] sh_a  [1024];
  bit          shw_a [1024];

  function automatic logic [31:0] exp_word(input int sel, input logic [9:0] a);
    if (sel == 0 && shw_a[a]) return sh_a[a];
    return (sel == 0) ? {22'h280000, a} : {22'h2C0000, a};
  endfunction

  int total = 0;
  int passed = 0;
  int n_fail = 0;
  int inv_viol = 0;
  int done_cnt_a = 0;
  int ack_cnt_a = 0;

  always @(negedge clock) begin
    if (ifa.mem_ren && ifa.mem_wen) inv_viol++;
    if (ifb.mem_ren && ifb.mem_wen) inv_viol++;
    if (ifa.refill_valid && !ifa.mem_ren) inv_viol++;
    if (ifb.refill_valid && !ifb.mem_ren) inv_viol++;
    if (ifa.refill_done) done_cnt_a++;
    if (ifa.ld_ack) ack_cnt_a++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } beat_t;
  beat_t sb[$];

  // Drives a miss, scoreboards every beat, returns in the IDLE cycle after refill_done
  task automatic refill(input int sel, input logic [9:0] addr, input int lat, input int bw,
                        input bit inject);
    logic [9:0]  base;
    logic        v, dn, ren, wen;
    logic [2:0]  idx_s;
    logic [9:0]  addr_s;
    logic [31:0] dat_s;
    int          cyc, extra;
    bit          done_seen, wen_seen;
    beat_t       e;
    base = addr & ~10'(bw - 1);
    for (int k = 0; k < bw; k++) begin
      e.idx  = 3'(k);
      e.addr = base | 10'(k);
      e.data = exp_word(sel, base | 10'(k));
      e.done = (k == bw - 1);
      e.cyc  = lat + k;
      sb.push_back(e);
    end
    if (sel == 0) begin ifa.miss_addr = addr; ifa.miss_req = 1'b1; end
    else          begin ifb.miss_addr = addr; ifb.miss_req = 1'b1; end
    tick();
    cyc = 0; extra = 0; done_seen = 0; wen_seen = 0;
    check("accept_busy", (sel == 0) ? ifa.busy : ifb.busy, 1'b1);
    while (!done_seen && cyc < 40) begin
      v      = (sel == 0) ? ifa.refill_valid : ifb.refill_valid;
      dn     = (sel == 0) ? ifa.refill_done  : ifb.refill_done;
      ren    = (sel == 0) ? ifa.mem_ren      : ifb.mem_ren;
      wen    = (sel == 0) ? ifa.mem_wen      : ifb.mem_wen;
      idx_s  = (sel == 0) ? {1'b0, ifa.refill_idx} : ifb.refill_idx;
      addr_s = (sel == 0) ? ifa.mem_addr     : ifb.mem_addr;
      dat_s  = (sel == 0) ? ifa.refill_data  : ifb.refill_data;
      if (wen) wen_seen = 1;
      if (cyc < lat) begin
        check("lat_no_valid", v, 1'b0);
        check("lat_ren", ren, 1'b1);
        check("lat_addr", addr_s, base);
      end
      if (v) begin
        if (sb.size() == 0) extra++;
        else begin
          e = sb.pop_front();
          check("beat_idx", idx_s, e.idx);
          check("beat_addr", addr_s, e.addr);
          check("beat_data", dat_s, e.data);
          check("beat_done", dn, e.done);
          check("beat_cycle", cyc, e.cyc);
        end
        if (dn) begin
          done_seen = 1;
          if (sel == 0) ifa.miss_req = 1'b0; else ifb.miss_req = 1'b0;
        end
        if (inject && sel == 0 && idx_s == 3'd0) begin
          ifa.ld_addr = 10'h055;
          ifa.ld_data = 32'hCAFEF00D;
          ifa.ld_req  = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    if (sel == 0) ifa.miss_req = 1'b0; else ifb.miss_req = 1'b0;
    check("beats_left", sb.size(), 0);
    check("extra_beats", extra, 0);
    check("wen_during_refill", wen_seen, 1'b0);
    check("post_busy", (sel == 0) ? ifa.busy : ifb.busy, 1'b0);
    check("post_valid", (sel == 0) ? ifa.refill_valid : ifb.refill_valid, 1'b0);
    sb.delete();
  endtask

  int snap;

  initial begin
    ifa.miss_req = 0; ifa.miss_addr = '0; ifa.ld_req = 0; ifa.ld_addr = '0; ifa.ld_data = '0;
    ifb.miss_req = 0; ifb.miss_addr = '0; ifb.ld_req = 0; ifb.ld_addr = '0; ifb.ld_data = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy_a", ifa.busy, 1'b0);
    check("rst_ren_a", ifa.mem_ren, 1'b0);
    check("rst_wen_a", ifa.mem_wen, 1'b0);
    check("rst_addr_a", ifa.mem_addr, 10'h000);
    check("rst_valid_a", ifa.refill_valid, 1'b0);
    check("rst_busy_b", ifb.busy, 1'b0);
    check("rst_ren_b", ifb.mem_ren, 1'b0);
    reset = 1'b0;
    tick();

    // Default refill: line 0x010..0x013
    refill(0, 10'h013, 2, 4, 0);

    // Zero latency, 8-word line at top of memory
    refill(1, 10'h3FF, 0, 8, 0);

    // Loader write then read back through a refill
    ifa.ld_addr = 10'h020; ifa.ld_data = 32'hDEADBEEF; ifa.ld_req = 1'b1;
    tick();
    check("ld_wen", ifa.mem_wen, 1'b1);
    check("ld_ack", ifa.ld_ack, 1'b1);
    check("ld_ren", ifa.mem_ren, 1'b0);
    check("ld_addr", ifa.mem_addr, 10'h020);
    check("ld_din", ifa.mem_din, 32'hDEADBEEF);
    ifa.ld_req = 1'b0;
    sh_a[10'h020] = 32'hDEADBEEF; shw_a[10'h020] = 1'b1;
    tick();
    check("ld_ack_drop", ifa.ld_ack, 1'b0);
    check("ld_idle", ifa.busy, 1'b0);
    refill(0, 10'h020, 2, 4, 0);

    // Collision: write wins, miss served on return to IDLE
    ifa.miss_addr = 10'h030; ifa.miss_req = 1'b1;
    ifa.ld_addr = 10'h031; ifa.ld_data = 32'h12345678; ifa.ld_req = 1'b1;
    tick();
    check("col_wen", ifa.mem_wen, 1'b1);
    check("col_ack", ifa.ld_ack, 1'b1);
    check("col_ren", ifa.mem_ren, 1'b0);
    check("col_addr", ifa.mem_addr, 10'h031);
    ifa.ld_req = 1'b0;
    sh_a[10'h031] = 32'h12345678; shw_a[10'h031] = 1'b1;
    tick();
    check("col_idle", ifa.busy, 1'b0);
    refill(0, 10'h030, 2, 4, 0);

    // Loader request raised mid-burst waits for IDLE
    snap = ack_cnt_a;
    refill(0, 10'h100, 2, 4, 1);
    check("busy_no_ack", ack_cnt_a - snap, 0);
    tick();
    check("held_ld_ack", ifa.ld_ack, 1'b1);
    check("held_ld_addr", ifa.mem_addr, 10'h055);
    check("held_ld_din", ifa.mem_din, 32'hCAFEF00D);
    ifa.ld_req = 1'b0;
    sh_a[10'h055] = 32'hCAFEF00D; shw_a[10'h055] = 1'b1;
    tick();
    refill(0, 10'h054, 2, 4, 0);

    // Reset held two cycles mid-burst
    snap = done_cnt_a;
    ifa.miss_addr = 10'h200; ifa.miss_req = 1'b1;
    tick();
    tick();
    tick();
    check("mid_burst_valid", ifa.refill_valid, 1'b1);
    reset = 1'b1; ifa.miss_req = 1'b0;
    tick();
    tick();
    check("rb_busy", ifa.busy, 1'b0);
    check("rb_valid", ifa.refill_valid, 1'b0);
    check("rb_ren", ifa.mem_ren, 1'b0);
    check("rb_addr", ifa.mem_addr, 10'h000);
    check("rb_idx", ifa.refill_idx, 2'd0);
    check("rb_no_done", done_cnt_a - snap, 0);
    reset = 1'b0;
    tick();
    check("rb_still_idle", ifa.busy, 1'b0);

    // Reset landing on the WRITE cycle: no write, no ack
    snap = ack_cnt_a;
    ifa.ld_addr = 10'h077; ifa.ld_data = 32'h0BADF00D; ifa.ld_req = 1'b1;
    tick();
    reset = 1'b1; ifa.ld_req = 1'b0;
    #1;
    check("rw_wen", ifa.mem_wen, 1'b0);
    check("rw_ack", ifa.ld_ack, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("rw_no_ack", ack_cnt_a - snap, 0);
    refill(0, 10'h074, 2, 4, 0);

    check("invariants", inv_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
